fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed-configuration FIFO in the SPI/RAM subsystem.
- Generalised in width and depth; depth need not be a power of two.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and a first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer in a single clock domain.

---
 rtl/fifo_sync_param_pkg.sv | 20 ++
 rtl/fifo_sync_param_storage.sv | 30 +++
 rtl/fifo_sync_param.sv | 125 ++++++++++++
 tb/tb_fifo_sync_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   FIFO_WIDTH_DEF / FIFO_DEPTH_DEF : default data width and entry count
//   fifo_mode_t                     : read mode, standard (registered) or first-word-fall-through
//   cnt_w()                         : bits needed to hold an occupancy of 0..depth
package pack_FIFO;

   localparam int FIFO_WIDTH_DEF = 16;
   localparam int FIFO_DEPTH_DEF = 8;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_t;

   // Occupancy runs 0..depth inclusive, so one more state than the entry count.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_sync_param_storage.sv
// Register-array storage for fifo_sync_param.
//   clk   : write clock
//   we    : write enable, mem[waddr] <= wdata on the rising edge
//   waddr : write address (0..DEPTH-1)
//   wdata : write data
//   raddr : read address (0..DEPTH-1)
//   rdata : asynchronous read data, mem[raddr]
// No reset on the array: contents are only meaningful between the pointers.
module fifo_storage #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and selectable
// standard or first-word-fall-through read mode.
//   clk, rst     : clock, synchronous active-high reset
//   data_in      : write data, taken when wr_en && !full
//   wr_en, rd_en : write / read requests (rd_en is the pop acknowledge in FWFT)
//   flush        : synchronous clear of contents, below reset in priority
//   data_out     : STD: registered read data; FWFT: head word while !empty
//   rd_valid     : STD only, pulse marking a data_out update
//   count        : occupancy 0..FIFO_DEPTH
//   full, almostfull, empty, almostempty : decodes of registered count
//   overflow, underflow, wr_ack          : registered single-cycle pulses
module fifo_sync_param
   import pack_FIFO::*;
#(
   parameter int         FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int         AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int         AE_LEVEL   = 2,
   parameter fifo_mode_t RD_MODE    = FIFO_STD
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [FIFO_WIDTH-1:0]            data_in,
   input  logic                             wr_en,
   input  logic                             rd_en,
   input  logic                             flush,
   output logic [FIFO_WIDTH-1:0]            data_out,
   output logic                             rd_valid,
   output logic [cnt_w(FIFO_DEPTH)-1:0]     count,
   output logic                             full,
   output logic                             almostfull,
   output logic                             empty,
   output logic                             almostempty,
   output logic                             overflow,
   output logic                             underflow,
   output logic                             wr_ack
);

   localparam int CW = cnt_w(FIFO_DEPTH);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   if (FIFO_DEPTH < 4) begin : g_bad_depth
      $error("fifo_sync_param: FIFO_DEPTH=%0d must be >= 4", FIFO_DEPTH);
   end
   if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
      $error("fifo_sync_param: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, FIFO_DEPTH);
   end
   if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_param: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, FIFO_DEPTH - 1);
   end

   logic [AW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [FIFO_WIDTH-1:0] rd_data, dout_q;
   logic                  wr_acc, rd_acc, mem_we;

   // Status flags decode the registered count only.
   assign full        = (count == CW'(FIFO_DEPTH));
   assign empty       = (count == '0);
   assign almostfull  = (count >= CW'(AF_LEVEL));
   assign almostempty = (count <= CW'(AE_LEVEL));

   // Acceptance uses pre-edge state: a same-cycle read never frees a slot
   // for a write on a full FIFO, and a same-cycle write never feeds a read
   // on an empty one.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;
   assign mem_we = wr_acc && !rst && !flush;

   // Depth need not be a power of two, so wrap explicitly.
   always_comb begin
      wr_ptr_nxt = (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      rd_ptr_nxt = (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
   end

   fifo_storage #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .AW    (AW)
   ) u_storage (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         dout_q    <= '0;
         rd_valid  <= 1'b0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         // data_out deliberately holds across a flush.
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr_nxt;
         if (rd_acc) rd_ptr <= rd_ptr_nxt;
         if (wr_acc && !rd_acc)      count <= count + CW'(1);
         else if (rd_acc && !wr_acc) count <= count - CW'(1);
         if (RD_MODE == FIFO_STD && rd_acc) dout_q <= rd_data;
         rd_valid  <= (RD_MODE == FIFO_STD) && rd_acc;
         wr_ack    <= wr_acc;
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

   // FWFT shows the head word straight from the array; while empty it
   // falls back to the (reset-cleared) register so the output stays defined.
   assign data_out = (RD_MODE == FIFO_FWFT && !empty) ? rd_data : dout_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;
   import pack_FIFO::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // standard-mode DUT
   logic        rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
   logic [15:0] data_in = '0, data_out;
   logic [3:0]  count;
   logic        rd_valid, full, almostfull, empty, almostempty, overflow, underflow, wr_ack;

   // FWFT-mode DUT
   logic        f_rst = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0, f_flush = 1'b0;
   logic [15:0] f_data_in = '0, f_data_out;
   logic [3:0]  f_count;
   logic        f_rd_valid, f_full, f_almostfull, f_empty, f_almostempty;
   logic        f_overflow, f_underflow, f_wr_ack;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] sb[$];
   logic [15:0] exp_d;

   fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2),
                     .RD_MODE(FIFO_STD)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
      .flush(flush), .data_out(data_out), .rd_valid(rd_valid), .count(count),
      .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty),
      .overflow(overflow), .underflow(underflow), .wr_ack(wr_ack));

   fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2),
                     .RD_MODE(FIFO_FWFT)) dut_f (
      .clk(clk), .rst(f_rst), .data_in(f_data_in), .wr_en(f_wr_en), .rd_en(f_rd_en),
      .flush(f_flush), .data_out(f_data_out), .rd_valid(f_rd_valid), .count(f_count),
      .full(f_full), .almostfull(f_almostfull), .empty(f_empty), .almostempty(f_almostempty),
      .overflow(f_overflow), .underflow(f_underflow), .wr_ack(f_wr_ack));

   // Drive one cycle on the STD DUT, sample 1 time unit after the edge.
   // Writes are pushed on the scoreboard when the bench expects acceptance.
   task automatic step(input logic w, input logic r, input logic fl,
                       input logic [15:0] d, input logic push);
      wr_en = w; rd_en = r; flush = fl; data_in = d;
      if (push) sb.push_back(d);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
   endtask

   task automatic f_step(input logic w, input logic r, input logic [15:0] d);
      f_wr_en = w; f_rd_en = r; f_data_in = d;
      @(posedge clk); #1;
      f_wr_en = 1'b0; f_rd_en = 1'b0;
   endtask

   // Pop the scoreboard head and compare it with data_out on a read pulse.
   task automatic check_read(input string tag);
      n_checks++;
      if (rd_valid !== 1'b1) begin
         n_fail++; $display("FAIL %s rd_valid: got %b want 1", tag, rd_valid);
      end else if (sb.size() == 0) begin
         n_fail++; $display("FAIL %s scoreboard empty, got data %h", tag, data_out);
      end else begin
         exp_d = sb.pop_front();
         n_checks++;
         if (data_out !== exp_d) begin
            n_fail++; $display("FAIL %s data_out: got %h want %h", tag, data_out, exp_d);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; f_rst = 1'b1;
      step(1'b1, 1'b0, 1'b0, 16'hDEAD, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'hDEAD, 1'b0);
      rst = 1'b0; f_rst = 1'b0;
      n_checks += 11;
      if (count !== 4'd0)       begin n_fail++; $display("FAIL reset count: got %0d want 0", count); end
      if (empty !== 1'b1)       begin n_fail++; $display("FAIL reset empty: got %b want 1", empty); end
      if (almostempty !== 1'b1) begin n_fail++; $display("FAIL reset almostempty: got %b want 1", almostempty); end
      if (full !== 1'b0)        begin n_fail++; $display("FAIL reset full: got %b want 0", full); end
      if (almostfull !== 1'b0)  begin n_fail++; $display("FAIL reset almostfull: got %b want 0", almostfull); end
      if (wr_ack !== 1'b0)      begin n_fail++; $display("FAIL reset wr_ack: got %b want 0", wr_ack); end
      if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset overflow: got %b want 0", overflow); end
      if (underflow !== 1'b0)   begin n_fail++; $display("FAIL reset underflow: got %b want 0", underflow); end
      if (rd_valid !== 1'b0)    begin n_fail++; $display("FAIL reset rd_valid: got %b want 0", rd_valid); end
      if (data_out !== 16'h0)   begin n_fail++; $display("FAIL reset data_out: got %h want 0000", data_out); end
      if (f_empty !== 1'b1 || f_count !== 4'd0) begin
         n_fail++; $display("FAIL reset fwft empty/count: got %b/%0d want 1/0", f_empty, f_count);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b0, 16'h1000 + 16'(i), 1'b1);
         n_checks += 5;
         if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL fill wr_ack[%0d]: got %b want 1", i, wr_ack); end
         if (count !== 4'(i + 1)) begin n_fail++; $display("FAIL fill count[%0d]: got %0d want %0d", i, count, i + 1); end
         if (almostempty !== (i + 1 <= 2)) begin n_fail++; $display("FAIL fill almostempty[%0d]: got %b want %b", i, almostempty, (i + 1 <= 2)); end
         if (almostfull !== (i + 1 >= 6)) begin n_fail++; $display("FAIL fill almostfull[%0d]: got %b want %b", i, almostfull, (i + 1 >= 6)); end
         if (full !== (i + 1 == 8)) begin n_fail++; $display("FAIL fill full[%0d]: got %b want %b", i, full, (i + 1 == 8)); end
      end
      step(1'b1, 1'b0, 1'b0, 16'h1FFF, 1'b0);
      n_checks += 3;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill overflow: got %b want 1", overflow); end
      if (wr_ack !== 1'b0)   begin n_fail++; $display("FAIL fill 9th wr_ack: got %b want 0", wr_ack); end
      if (count !== 4'd8)    begin n_fail++; $display("FAIL fill 9th count: got %0d want 8", count); end
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill overflow pulse: got %b want 0", overflow); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
         check_read("drain");
         n_checks++;
         if (count !== 4'(7 - i)) begin n_fail++; $display("FAIL drain count[%0d]: got %0d want %0d", i, count, 7 - i); end
      end
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      n_checks += 4;
      if (underflow !== 1'b1)   begin n_fail++; $display("FAIL drain underflow: got %b want 1", underflow); end
      if (rd_valid !== 1'b0)    begin n_fail++; $display("FAIL drain 9th rd_valid: got %b want 0", rd_valid); end
      if (data_out !== 16'h1007) begin n_fail++; $display("FAIL drain hold data_out: got %h want 1007", data_out); end
      if (empty !== 1'b1)       begin n_fail++; $display("FAIL drain empty: got %b want 1", empty); end
   endtask

   task automatic test_wrap_concurrent();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h2000 + 16'(i), 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'h2004 + 16'(i), 1'b1);
         check_read("stream");
         n_checks += 2;
         if (count !== 4'd4) begin n_fail++; $display("FAIL stream count[%0d]: got %0d want 4", i, count); end
         if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL stream wr_ack[%0d]: got %b want 1", i, wr_ack); end
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
         check_read("stream drain");
      end
      n_checks++;
      if (count !== 4'd0) begin n_fail++; $display("FAIL stream final count: got %0d want 0", count); end
   endtask

   task automatic test_boundaries();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h3000 + 16'(i), 1'b1);
      step(1'b1, 1'b1, 1'b0, 16'h3FFF, 1'b0);   // write refused, read taken
      check_read("full rw");
      n_checks += 3;
      if (count !== 4'd7)    begin n_fail++; $display("FAIL full rw count: got %0d want 7", count); end
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL full rw overflow: got %b want 1", overflow); end
      if (wr_ack !== 1'b0)   begin n_fail++; $display("FAIL full rw wr_ack: got %b want 0", wr_ack); end
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
         check_read("full rw drain");
      end
      step(1'b1, 1'b1, 1'b0, 16'h4444, 1'b1);   // write taken, read refused
      n_checks += 4;
      if (count !== 4'd1)     begin n_fail++; $display("FAIL empty rw count: got %0d want 1", count); end
      if (underflow !== 1'b1) begin n_fail++; $display("FAIL empty rw underflow: got %b want 1", underflow); end
      if (wr_ack !== 1'b1)    begin n_fail++; $display("FAIL empty rw wr_ack: got %b want 1", wr_ack); end
      if (rd_valid !== 1'b0)  begin n_fail++; $display("FAIL empty rw rd_valid: got %b want 0", rd_valid); end
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      check_read("empty rw readback");
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h5000 + 16'(i), 1'b0);
      n_checks++;
      if (count !== 4'd5) begin n_fail++; $display("FAIL flush pre count: got %0d want 5", count); end
      step(1'b1, 1'b0, 1'b1, 16'h5555, 1'b0);
      n_checks += 4;
      if (count !== 4'd0)       begin n_fail++; $display("FAIL flush count: got %0d want 0", count); end
      if (empty !== 1'b1)       begin n_fail++; $display("FAIL flush empty: got %b want 1", empty); end
      if (wr_ack !== 1'b0)      begin n_fail++; $display("FAIL flush wr_ack: got %b want 0", wr_ack); end
      if (data_out !== 16'h4444) begin n_fail++; $display("FAIL flush hold data_out: got %h want 4444", data_out); end
      // pointers restart at 0: next write comes straight back out
      step(1'b1, 1'b0, 1'b0, 16'h6000, 1'b1);
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      check_read("post flush");
   endtask

   task automatic test_fwft();
      f_step(1'b1, 1'b0, 16'hABCD);
      n_checks += 3;
      if (f_empty !== 1'b0)        begin n_fail++; $display("FAIL fwft empty after write: got %b want 0", f_empty); end
      if (f_data_out !== 16'hABCD) begin n_fail++; $display("FAIL fwft head: got %h want abcd", f_data_out); end
      if (f_rd_valid !== 1'b0)     begin n_fail++; $display("FAIL fwft rd_valid: got %b want 0", f_rd_valid); end
      f_step(1'b0, 1'b1, 16'h0);
      n_checks += 2;
      if (f_empty !== 1'b1)  begin n_fail++; $display("FAIL fwft empty after pop: got %b want 1", f_empty); end
      if (f_count !== 4'd0)  begin n_fail++; $display("FAIL fwft count after pop: got %0d want 0", f_count); end
      f_step(1'b1, 1'b0, 16'h1111);
      f_step(1'b1, 1'b0, 16'h2222);
      n_checks++;
      if (f_data_out !== 16'h1111) begin n_fail++; $display("FAIL fwft head1: got %h want 1111", f_data_out); end
      f_step(1'b0, 1'b1, 16'h0);
      n_checks += 2;
      if (f_data_out !== 16'h2222) begin n_fail++; $display("FAIL fwft head2: got %h want 2222", f_data_out); end
      if (f_count !== 4'd1)        begin n_fail++; $display("FAIL fwft count: got %0d want 1", f_count); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap_concurrent();
      test_boundaries();
      test_flush();
      test_fwft();
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
